apb_req_arbiter: RTL and testbench

- Shares one APB completer (the memory-backed APB slave) between NUM_REQ local requesters.
- Each requester posts a command (addr, write, wdata, strobe) with a req/ack handshake.
- The arbiter picks a winner round-robin, runs the APB SETUP/ACCESS sequence, returns rdata/slverr, and asserts trnsfr for back-to-back transfers.
- Sits between the bridge's request side and the completer's apbif master-side signals.

---
 rtl/apb_req_arbiter_pkg.sv | 24 ++
 rtl/apb_req_arbiter_if.sv | 30 +++
 rtl/apb_req_arbiter_rr_picker.sv | 31 +++
 rtl/apb_req_arbiter.sv | 138 +++++++++++++
 tb/tb_apb_req_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_req_arbiter_pkg.sv
// Shared types for the APB request arbiter: FSM states, default widths and
// the default-width command record used around the arbiter.
package apb_arb_pkg;

  localparam int APB_NUM_REQ    = 2;
  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;
  localparam int APB_STRB_WIDTH = APB_DATA_WIDTH / 8;
  localparam int APB_TIMEOUT    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_arb_state_t;

  typedef struct packed {
    logic [APB_ADDR_WIDTH-1:0] addr;
    logic                      write;
    logic [APB_DATA_WIDTH-1:0] wdata;
    logic [APB_STRB_WIDTH-1:0] strobe;
  } apb_cmd_t;

endpackage

// File: rtl/apb_req_arbiter_if.sv
// APB requester-to-completer bus as seen by the arbiter (master) and the
// memory-backed completer (slave).
interface apb_arb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  sel;
  logic                  enable;
  logic                  write;
  logic                  trnsfr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] strobe;
  logic                  ready;
  logic                  slverr;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output sel, enable, write, trnsfr, addr, wdata, strobe,
    input  ready, slverr, rdata
  );

  modport slave (
    input  sel, enable, write, trnsfr, addr, wdata, strobe,
    output ready, slverr, rdata
  );

endinterface

// File: rtl/apb_req_arbiter_rr_picker.sv
// Round-robin priority select: first set req bit at or above ptr, wrapping
// to the bottom of the vector.
module rr_picker #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] winner
);

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    // upper region [ptr, N) first, then the wrapped region [0, ptr)
    for (int i = 0; i < N; i++) begin
      if (!valid && req[i] && (i >= int'(ptr))) begin
        valid  = 1'b1;
        winner = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!valid && req[i]) begin
        valid  = 1'b1;
        winner = IW'(i);
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB completer between NUM_REQ requesters: round-robin grant,
// SETUP/ACCESS sequencing with a ready timeout, one-hot ack with response.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ    = APB_NUM_REQ,
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int TIMEOUT    = APB_TIMEOUT,
  localparam int STRB_WIDTH = DATA_WIDTH / 8,
  localparam int IW         = $clog2(NUM_REQ)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]                   req_write,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ-1:0][STRB_WIDTH-1:0]   req_strobe,
  output logic [NUM_REQ-1:0]                   ack,
  output logic [DATA_WIDTH-1:0]                rsp_rdata,
  output logic                                 rsp_err,
  output logic [IW-1:0]                        gnt_id,
  apb_arb_if.master                            apb
);

  localparam int CW = $clog2(TIMEOUT);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] strobe;
  } cmd_t;

  apb_arb_state_t           state;
  cmd_t                     cmd;
  cmd_t [NUM_REQ-1:0]       req_cmd;
  logic [IW-1:0]            ptr;
  logic [CW-1:0]            cnt;
  logic                     trnsfr_q;
  logic                     done;
  logic                     pick_vld;
  logic [IW-1:0]            pick_id;
  logic [IW-1:0]            pick_ptr;
  logic [IW-1:0]            gnt_nxt;
  logic [NUM_REQ-1:0]       pick_req;

  function automatic logic [IW-1:0] nxt_id(input logic [IW-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cmd
    assign req_cmd[g] = '{addr: req_addr[g], write: req_write[g],
                          wdata: req_wdata[g], strobe: req_strobe[g]};
  end

  assign gnt_nxt = nxt_id(gnt_id);
  assign done    = (state == ACCESS) && (apb.ready || (cnt == CW'(TIMEOUT - 1)));

  // On the completing ACCESS cycle the owner is excluded and the search
  // starts just above it; in IDLE the requester acked last cycle may still
  // be dropping req, so it is masked for that one cycle.
  always_comb begin
    pick_ptr = ptr;
    pick_req = req & ~ack;
    if (state == ACCESS) begin
      pick_ptr          = gnt_nxt;
      pick_req          = req;
      pick_req[gnt_id]  = 1'b0;
    end
  end

  rr_picker #(.N(NUM_REQ)) u_pick (
    .req    (pick_req),
    .ptr    (pick_ptr),
    .valid  (pick_vld),
    .winner (pick_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd       <= '0;
      ptr       <= '0;
      cnt       <= '0;
      gnt_id    <= '0;
      ack       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      trnsfr_q  <= 1'b0;
    end else begin
      ack       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      trnsfr_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            cmd    <= req_cmd[pick_id];
            gnt_id <= pick_id;
            state  <= SETUP;
          end
        end
        SETUP: state <= ACCESS;
        ACCESS: begin
          if (done) begin
            ack[gnt_id] <= 1'b1;
            rsp_rdata   <= (apb.ready && !cmd.write) ? apb.rdata : '0;
            rsp_err     <= apb.ready ? apb.slverr : 1'b1;
            cnt         <= '0;
            ptr         <= gnt_nxt;
            if (pick_vld) begin
              trnsfr_q <= 1'b1;
              cmd      <= req_cmd[pick_id];
              gnt_id   <= pick_id;
              state    <= SETUP;
            end else begin
              state    <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign apb.sel    = (state != IDLE);
  assign apb.enable = (state == ACCESS);
  assign apb.trnsfr = trnsfr_q;
  assign apb.addr   = apb.sel ? cmd.addr   : '0;
  assign apb.write  = apb.sel ? cmd.write  : 1'b0;
  assign apb.wdata  = apb.sel ? cmd.wdata  : '0;
  assign apb.strobe = apb.sel ? cmd.strobe : '0;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Randomized bench for apb_req_arbiter with a memory-backed APB completer
// and a transaction-level round-robin / memory reference model.
module tb_apb_req_arbiter;
  import apb_arb_pkg::*;

  localparam int NREQ     = 3;
  localparam int TO       = 16;
  localparam int MEM_BYTE = 256;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ-1:0][31:0]  req_addr = '0;
  logic [NREQ-1:0]        req_write = '0;
  logic [NREQ-1:0][31:0]  req_wdata = '0;
  logic [NREQ-1:0][3:0]   req_strobe = '0;
  logic [NREQ-1:0]        ack;
  logic [31:0]            rsp_rdata;
  logic                   rsp_err;
  logic [1:0]             gnt_id;

  apb_arb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_req_arbiter #(.NUM_REQ(NREQ), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_write(req_write),
    .req_wdata(req_wdata), .req_strobe(req_strobe), .ack(ack), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .gnt_id(gnt_id), .apb(bus)
  );

  always #5 clk = ~clk;

  // completer: ready after wait_n ACCESS wait cycles, slverr beyond MEM_BYTE
  int unsigned wait_n = 1;
  int unsigned acc = 0;
  bit          init_done = 1'b0;
  logic [31:0] cmem [0:63];
  logic        in_rng;

  assign in_rng     = bus.addr < MEM_BYTE;
  assign bus.ready  = bus.sel && bus.enable && (acc >= wait_n);
  assign bus.slverr = bus.ready && !in_rng;
  assign bus.rdata  = (bus.ready && in_rng && !bus.write) ? cmem[bus.addr[7:2]] : '0;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 64; i++) cmem[i] <= '0;
    end else if (bus.ready && bus.write && in_rng) begin
      for (int b = 0; b < 4; b++)
        if (bus.strobe[b]) cmem[bus.addr[7:2]][8*b +: 8] <= bus.wdata[8*b +: 8];
    end
    if (bus.sel && bus.enable && !bus.ready) acc <= acc + 1;
    else acc <= 0;
  end

  // reference model state
  logic [7:0]  mmem [0:MEM_BYTE-1];
  int          mptr = 0;
  apb_cmd_t    cmd_q [NREQ];
  logic [31:0] last_rdata;
  int          tot = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mword(input logic [31:0] a);
    return {mmem[{a[7:2], 2'd3}], mmem[{a[7:2], 2'd2}], mmem[{a[7:2], 2'd1}], mmem[{a[7:2], 2'd0}]};
  endfunction

  // Serve every requester in mask, all raised together onto an idle arbiter
  // and each held until its own ack. Expected schedule: SETUP + A ACCESS
  // cycles per transfer, back to back, in round-robin order from mptr.
  task automatic run_round(input logic [NREQ-1:0] mask, input bit sync);
    int       order[$];
    bit       rdy;
    int       a_cyc, k, t, last, j, id;
    logic     inr;
    apb_cmd_t c;
    if (sync) @(negedge clk);
    order = {};
    for (int o = 0; o < NREQ; o++)
      if (mask[(mptr + o) % NREQ]) order.push_back((mptr + o) % NREQ);
    rdy   = (wait_n + 1) <= TO;
    a_cyc = rdy ? int'(wait_n) + 1 : TO;
    for (int i = 0; i < NREQ; i++) begin
      if (mask[i]) begin
        req_addr[i]   = cmd_q[i].addr;
        req_write[i]  = cmd_q[i].write;
        req_wdata[i]  = cmd_q[i].wdata;
        req_strobe[i] = cmd_q[i].strobe;
      end
    end
    req  = req | mask;
    k    = 0;
    last = order.size() * (a_cyc + 1) + 1;
    for (t = 1; t <= last; t++) begin
      @(negedge clk);
      if (t <= order.size() * (a_cyc + 1)) begin
        j = (t - 1) / (a_cyc + 1);
        chk("sel", 32'(bus.sel), 32'd1);
        chk("enable", 32'(bus.enable), 32'(((t - 1) % (a_cyc + 1)) != 0));
        chk("addr", bus.addr, cmd_q[order[j]].addr);
        chk("gnt_id", 32'(gnt_id), 32'(order[j]));
      end else begin
        chk("sel_idle", 32'(bus.sel), 32'd0);
      end
      if (k < order.size() && t == 2 + a_cyc + k * (1 + a_cyc)) begin
        id  = order[k];
        c   = cmd_q[id];
        inr = c.addr < MEM_BYTE;
        chk("ack", 32'(ack), 32'(1 << id));
        chk("trnsfr", 32'(bus.trnsfr), 32'(k + 1 < order.size()));
        if (!rdy) begin
          chk("rsp_err", 32'(rsp_err), 32'd1);
          chk("rsp_rdata", rsp_rdata, 32'd0);
        end else begin
          chk("rsp_err", 32'(rsp_err), 32'(!inr));
          chk("rsp_rdata", rsp_rdata, (!c.write && inr) ? mword(c.addr) : 32'd0);
          if (c.write && inr)
            for (int b = 0; b < 4; b++)
              if (c.strobe[b]) mmem[{c.addr[7:2], 2'(b)}] = c.wdata[8*b +: 8];
        end
        last_rdata = rsp_rdata;
        req[id]    = 1'b0;
        mptr       = (id + 1) % NREQ;
        k++;
      end else begin
        chk("ack_quiet", 32'(ack), 32'd0);
        chk("trnsfr_quiet", 32'(bus.trnsfr), 32'd0);
      end
    end
  endtask

  function automatic apb_cmd_t rnd_cmd();
    apb_cmd_t c;
    c.addr   = 32'($urandom_range(0, 79) * 4);
    c.write  = 1'($urandom_range(0, 1));
    c.wdata  = $urandom;
    c.strobe = 4'($urandom_range(0, 15));
    return c;
  endfunction

  initial begin
    for (int i = 0; i < MEM_BYTE; i++) mmem[i] = '0;
    for (int i = 0; i < NREQ; i++) cmd_q[i] = '0;
    last_rdata = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_sel", 32'(bus.sel), 32'd0);
    chk("rst_enable", 32'(bus.enable), 32'd0);
    chk("rst_trnsfr", 32'(bus.trnsfr), 32'd0);
    chk("rst_gnt", 32'(gnt_id), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_addr", bus.addr, 32'd0);
    chk("rst_wdata", bus.wdata, 32'd0);
    chk("rst_strobe", 32'(bus.strobe), 32'd0);
    init_done = 1'b1;
    rst_n     = 1'b1;

    // contention straight after reset: req0 first, trnsfr into req1
    cmd_q[0] = '{addr: 32'h20, write: 1'b1, wdata: 32'h1111_2222, strobe: 4'hF};
    cmd_q[1] = '{addr: 32'h24, write: 1'b1, wdata: 32'h3333_4444, strobe: 4'h3};
    run_round(3'b011, 1'b0);

    // single write, then read-back from another requester
    cmd_q[0] = '{addr: 32'h10, write: 1'b1, wdata: 32'hA5A5_1234, strobe: 4'hF};
    run_round(3'b001, 1'b1);
    chk("mem_wr", cmem[4], 32'hA5A5_1234);
    cmd_q[1] = '{addr: 32'h10, write: 1'b0, wdata: 32'h0, strobe: 4'h0};
    run_round(3'b010, 1'b1);
    chk("readback", last_rdata, 32'hA5A5_1234);

    // repeated contention
    repeat (3) run_round(3'b011, 1'b1);

    // out of range write and read
    cmd_q[0] = '{addr: 32'h200, write: 1'b1, wdata: 32'hDEAD_BEEF, strobe: 4'hF};
    cmd_q[2] = '{addr: 32'h300, write: 1'b0, wdata: 32'h0, strobe: 4'hF};
    run_round(3'b101, 1'b1);

    // timeout abort, alone and with a follower pending
    wait_n   = 1000;
    cmd_q[0] = '{addr: 32'h10, write: 1'b0, wdata: 32'h0, strobe: 4'h0};
    run_round(3'b001, 1'b1);
    run_round(3'b011, 1'b1);

    // ready arriving on the last allowed ACCESS cycle wins over timeout
    wait_n   = TO - 1;
    cmd_q[2] = '{addr: 32'h10, write: 1'b0, wdata: 32'h0, strobe: 4'h0};
    run_round(3'b100, 1'b1);

    // reset mid-ACCESS while requester 1 owns the bus
    wait_n   = 1;
    cmd_q[0] = '{addr: 32'h40, write: 1'b1, wdata: 32'h0BAD_F00D, strobe: 4'hF};
    run_round(3'b001, 1'b1);
    wait_n   = 5;
    cmd_q[0] = '{addr: 32'h44, write: 1'b1, wdata: 32'h5555_AAAA, strobe: 4'hF};
    cmd_q[1] = '{addr: 32'h48, write: 1'b1, wdata: 32'h6666_BBBB, strobe: 4'hC};
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      req_addr[i]   = cmd_q[i].addr;
      req_write[i]  = cmd_q[i].write;
      req_wdata[i]  = cmd_q[i].wdata;
      req_strobe[i] = cmd_q[i].strobe;
    end
    req = 3'b011;
    repeat (2) @(negedge clk);
    chk("pre_rst_enable", 32'(bus.enable), 32'd1);
    chk("pre_rst_gnt", 32'(gnt_id), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_sel", 32'(bus.sel), 32'd0);
    chk("rst_mid_enable", 32'(bus.enable), 32'd0);
    chk("rst_mid_gnt", 32'(gnt_id), 32'd0);
    @(negedge clk);
    chk("rst_mid_ack", 32'(ack), 32'd0);
    rst_n  = 1'b1;
    mptr   = 0;
    wait_n = 1;
    run_round(3'b011, 1'b0);

    // randomized rounds
    for (int r = 0; r < 40; r++) begin
      logic [NREQ-1:0] m;
      case ($urandom_range(0, 9))
        0:       wait_n = TO - 1;
        1:       wait_n = TO;
        2:       wait_n = 1000;
        default: wait_n = $urandom_range(0, 3);
      endcase
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) cmd_q[i] = rnd_cmd();
      run_round(m, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
